// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
// Operation encoding follows the RV32M funct3 field.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    // Multiply family: funct3 MSB clear.
    function automatic logic is_mul(input mdu_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    endfunction

    // Divide family: funct3 MSB set.
    function automatic logic is_div(input mdu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    // Remainder-returning divide ops.
    function automatic logic is_rem(input mdu_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // rs1 interpreted as two's complement.
    function automatic logic is_signed_a(input mdu_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 interpreted as two's complement.
    function automatic logic is_signed_b(input mdu_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Shared shift/add-subtract datapath: radix-2 shift-add multiply and
// restoring divide on unsigned magnitudes, one bit per cycle.
// Accumulator layout: {hi, lo}. Multiply: lo starts as multiplier, final
// acc is the 2*XLEN product. Divide: lo starts as dividend, final hi is
// the remainder and lo the quotient.
module mdu_iter_core #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              start,
    input  logic              mode_div,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] acc,
    output logic              done
);

    localparam int CNT_W = $clog2(XLEN);

    logic [CNT_W-1:0]  cnt;
    logic              active;
    logic              mode_q;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc_step;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_ge;

    // Final iteration happens on the edge where this is high.
    assign done = active && (cnt == '0);

    // One iteration of either algorithm from the current accumulator.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_ge    = div_shift >= {1'b0, opnd};
        div_diff  = div_shift - {1'b0, opnd};
        acc_step  = {mul_sum, acc[XLEN-1:1]};
        if (mode_q) begin
            if (div_ge) begin
                acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_step = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end
    end

    // Operand load on start, then XLEN iterations counting down to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= '0;
            mode_q <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
        end else if (clear) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= CNT_W'(XLEN - 1);
            mode_q <= mode_div;
            opnd   <= b;
            acc    <= {{XLEN{1'b0}}, a};
        end else if (active) begin
            acc <= acc_step;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: FSM, handshake, sign handling and
// early-out special cases around the shared mdu_iter_core datapath.
// Optional macro MDU_FAST_MUL_EN: multiplies use a combinational multiplier
// sampled at accept and complete one cycle later; divides stay iterative.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; a response transfers on a rising edge where
// resp_valid and resp_ready are both high. req_valid/resp_valid never depend
// combinationally on the matching ready, and once raised resp_valid holds
// with stable result/tag until it transfers (or the op is flushed/reset).
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_result,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy,
    output mdu_state_e       state_dbg
);

    mdu_state_e        state, state_next;
    mdu_op_e           op_in, op_q;
    logic              accept;
    logic              sa_in, sb_in, neg_in, neg_q;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic              b_zero, div_ovf, special;
    logic [XLEN-1:0]   special_result;
    logic              fast_hit;
    logic [XLEN-1:0]   fast_result;
    logic              core_start, core_done;
    logic [2*XLEN-1:0] core_acc;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem;
    logic [XLEN-1:0]   fix_result;
    logic              resp_valid_q;
    logic [XLEN-1:0]   result_q;
    logic [TAG_W-1:0]  tag_q;

    assign op_in     = mdu_op_e'(req_op);
    assign req_ready = (state == IDLE) && !flush;
    assign accept    = req_valid && req_ready;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    assign resp_valid  = resp_valid_q;
    assign resp_result = result_q;
    assign resp_tag    = tag_q;

    // Request decode: sign flags, magnitudes and early-out detection.
    always_comb begin
        sa_in   = is_signed_a(op_in) && req_a[XLEN-1];
        sb_in   = is_signed_b(op_in) && req_b[XLEN-1];
        a_abs   = sa_in ? -req_a : req_a;
        b_abs   = sb_in ? -req_b : req_b;
        // Remainder follows the dividend; everything else follows sign xor.
        neg_in  = (is_div(op_in) && is_rem(op_in)) ? sa_in : (sa_in ^ sb_in);
        b_zero  = (req_b == '0);
        div_ovf = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                  (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_b == '1);
        special = is_div(op_in) && (b_zero || div_ovf);
        if (b_zero) begin
            special_result = is_rem(op_in) ? req_a : '1;
        end else begin
            special_result = is_rem(op_in) ? '0 : req_a;
        end
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_mag, fast_prod;
    assign fast_mag    = {{XLEN{1'b0}}, a_abs} * {{XLEN{1'b0}}, b_abs};
    assign fast_prod   = neg_in ? -fast_mag : fast_mag;
    assign fast_hit    = is_mul(op_in);
    assign fast_result = (op_in == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
    assign fast_hit    = 1'b0;
    assign fast_result = '0;
`endif

    mdu_iter_core #(
        .XLEN(XLEN)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .start    (core_start),
        .mode_div (is_div(op_in)),
        .a        (a_abs),
        .b        (b_abs),
        .acc      (core_acc),
        .done     (core_done)
    );

    // Sign correction and high/low selection from the finished accumulator.
    always_comb begin
        prod = neg_q ? -core_acc : core_acc;
        quot = core_acc[XLEN-1:0];
        rem  = core_acc[2*XLEN-1:XLEN];
        unique case (op_q)
            OP_MUL:                        fix_result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_result = neg_q ? -quot : quot;
            OP_REM, OP_REMU:               fix_result = neg_q ? -rem : rem;
            default:                       fix_result = '0;
        endcase
    end

    // Next-state logic; flush overrides everything and returns to IDLE.
    always_comb begin
        state_next = state;
        core_start = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (special || fast_hit) begin
                        state_next = DONE;
                    end else begin
                        state_next = CALC;
                        core_start = 1'b1;
                    end
                end
            end
            CALC: if (core_done) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
            core_start = 1'b0;
        end
    end

    // State, captured request context and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
            result_q     <= '0;
            tag_q        <= '0;
            op_q         <= OP_MUL;
            neg_q        <= 1'b0;
        end else begin
            state        <= state_next;
            resp_valid_q <= (state_next == DONE);
            if (accept) begin
                op_q  <= op_in;
                tag_q <= req_tag;
                neg_q <= neg_in;
                if (special) begin
                    result_q <= special_result;
                end else if (fast_hit) begin
                    result_q <= fast_result;
                end
            end
            if ((state == FIX) && !flush) begin
                result_q <= fix_result;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter (XLEN=32) with hand-computed expectations.
// Honours MDU_FAST_MUL_EN for expected multiply latency.
module tb_mdu_iter;
  import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic clk = 1'b0;
  logic rst, flush, req_valid, req_ready, resp_valid, resp_ready, busy;
  logic [2:0] req_op;
  logic [31:0] req_a, req_b, resp_result;
  logic [4:0] req_tag, resp_tag;
  mdu_state_e state_dbg;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  mdu_iter #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_tag(resp_tag),
    .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one request at a negedge; returns just after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    int w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Wait for the response, check latency/result/tag, hold, then handshake.
  task automatic collect(input string name, input logic [4:0] tag, input int lat, input int hold);
    int n;
    logic [31:0] exp;
    logic [31:0] r0;
    logic [4:0] t0;
    n = 0;
    exp = exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEAD_BEEF;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 100);
    if (!resp_valid) begin
      check({name, "_timeout"}, 32'(resp_valid), 32'd1);
      return;
    end
    check({name, "_lat"}, 32'(n), 32'(lat));
    check({name, "_res"}, resp_result, exp);
    check({name, "_tag"}, 32'(resp_tag), 32'(tag));
    r0 = resp_result;
    t0 = resp_tag;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_v"}, 32'(resp_valid), 32'd1);
      check({name, "_hold_r"}, resp_result, r0);
      check({name, "_hold_t"}, 32'(resp_tag), 32'(t0));
      check({name, "_hold_rdy"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check({name, "_post_rdy"}, 32'(req_ready), 32'd1);
    check({name, "_post_v"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp,
                        input int lat, input int hold);
    exp_q.push_back(exp);
    issue(op, a, b, tag);
    collect(name, tag, lat, hold);
  endtask

  // Watch a window for any response that should not appear.
  task automatic expect_quiet(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_result", resp_result, 32'd0);
    check("rst_tag", 32'(resp_tag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));

    // multiply
    run_op("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, MUL_LAT, 0);
    run_op("mulhu_m1", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, MUL_LAT, 0);
    run_op("mulh_m1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0000, MUL_LAT, 0);
    run_op("mulhsu_m1", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF, MUL_LAT, 0);
    run_op("mul_m1", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0001, MUL_LAT, 0);

    // divide
    run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFD, DIV_LAT, 0);
    run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFF, DIV_LAT, 0);
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd10, 32'd14, DIV_LAT, 0);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 5'd11, 32'd2, DIV_LAT, 0);

    // early-out special cases
    run_op("div_5_0", 3'b100, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 1, 0);
    run_op("rem_5_0", 3'b110, 32'd5, 32'd0, 5'd13, 32'd5, 1, 0);
    run_op("divu_5_0", 3'b101, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF, 1, 0);
    run_op("remu_5_0", 3'b111, 32'd5, 32'd0, 5'd15, 32'd5, 1, 0);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1, 0);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 1, 0);

    // backpressure: hold resp_ready low for 10 cycles in DONE
    run_op("hold_divu", 3'b101, 32'd100, 32'd7, 5'd21, 32'd14, DIV_LAT, 10);

    // flush together with req_valid: no accept
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_op = 3'b101; req_a = 32'd9; req_b = 32'd3; req_tag = 5'd1;
    #1 check("flush_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("flush_no_accept", 32'(busy), 32'd0);

    // flush 10 cycles into CALC
    issue(3'b101, 32'd1000, 32'd3, 5'd22);
    repeat (10) @(negedge clk);
    check("flush_in_calc", 32'(state_dbg), 32'(CALC));
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_idle", 32'(state_dbg), 32'(IDLE));
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_rdy", 32'(req_ready), 32'd1);
    expect_quiet("flush_no_resp", 40);
    run_op("after_flush", 3'b101, 32'd100, 32'd7, 5'd23, 32'd14, DIV_LAT, 0);

    // reset mid-CALC
    issue(3'b101, 32'd1000, 32'd3, 5'd24);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst2_valid", 32'(resp_valid), 32'd0);
    check("rst2_result", resp_result, 32'd0);
    check("rst2_tag", 32'(resp_tag), 32'd0);
    check("rst2_busy", 32'(busy), 32'd0);
    check("rst2_rdy", 32'(req_ready), 32'd1);
    expect_quiet("rst2_no_resp", 40);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit with a valid/ready request and response handshake, parametrised in XLEN.
- Sits beside the single-cycle integer ALU in the execute stage. The pipeline issues M-extension ops here and stalls on req_ready/resp_valid.
- Radix-2 shift-add multiply and restoring divide share one accumulator datapath.
- Divide-by-zero and signed overflow resolve early, without iterating.

Parameters:
- XLEN, 32, operand/result width; must be ≥ 8 and a power of two.
- TAG_W, 5, width of the opaque tag echoed with the result (e.g. rd index).

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill any in-flight op; synchronous.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- req_a  in  XLEN  rs1 operand.
- req_b  in  XLEN  rs2 operand.
- req_tag  in  TAG_W  tag, captured on accept.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer takes the result.
- resp_result  out  XLEN  result.
- resp_tag  out  TAG_W  captured tag.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state=IDLE; resp_valid=0, resp_result=0, resp_tag=0, busy=0; req_ready=1 in the cycle after reset deasserts.
- Reset mid-op discards the op. No response is produced.
- req_ready = (state==IDLE) && !flush.
- Accept occurs when req_valid && req_ready. On accept, op, tag, sign flags and absolute operand values are captured.
- States:
  - IDLE → CALC: normal accept.
  - IDLE → DONE: special-case accept.
  - CALC (counter from XLEN-1 down to 0, one bit per cycle) → FIX when the counter reaches 0.
  - FIX (sign correction and high/low select) → DONE.
  - DONE holds until resp_valid && resp_ready, then → IDLE.
- Latency: resp_valid first high XLEN+2 cycles after the accept edge for iterative ops (34 for XLEN=32). Special cases take 1 cycle.
- Throughput: no overlap. Earliest next accept is the cycle after the response handshake.
- In DONE, resp_result and resp_tag stay stable while resp_ready is low. All response outputs are registered.
- Multiply:
  - Unsigned XLEN×XLEN → 2·XLEN product of magnitudes; negate if the signs differ.
  - Sign rules: MUL/MULH treat both operands as signed. MULHSU: a signed, b unsigned. MULHU: both unsigned.
  - MUL returns product[XLEN-1:0]; the MULH* ops return product[2XLEN-1:XLEN].
- Divide:
  - Restoring divide on magnitudes.
  - Quotient negated if the signs differ (DIV). Remainder takes the sign of the dividend (REM).
- Special cases, detected at accept:
  - b==0: quotient = all ones; remainder = a. Applies to both signed and unsigned ops.
  - Signed DIV/REM with a = 100…0 and b = all ones: quotient = a; remainder = 0.
- Flush:
  - Any state → IDLE on the next edge.
  - resp_valid is 0 from that edge; a pending DONE result is dropped.
  - flush together with req_valid: no accept.
  - flush together with a resp handshake: the handshake completes and the state goes to IDLE.
- req_op values are all legal, so no illegal-op handling exists.

Optional Feature:
- Macro MDU_FAST_MUL_EN.
- Defined: all four multiply ops use a combinational XLEN×XLEN multiplier sampled at accept. The unit goes IDLE → DONE directly, so resp_valid comes 1 cycle after accept. Divide is unchanged.
- Undefined: multiply uses the iterative path (XLEN+2 cycles) and no hardware multiplier is inferred.

Decomposition:
- Package mdu_pkg holds:
  - mdu_op_e enum with the funct3 encoding above.
  - mdu_state_e enum {IDLE, CALC, FIX, DONE}.
  - Helper functions is_mul/is_div/is_signed_a/is_signed_b.
- One natural sub-module, mdu_iter_core, holds the shared shift/add-subtract datapath: 2·XLEN accumulator, operand register and bit counter, with start/mode inputs and a done output.
- mdu_iter keeps the FSM, handshake, sign logic and special cases.

Test Plan:
- MUL a=7, b=0xFFFFFFFD, tag=3 → resp_result=0xFFFFFFEB, resp_tag=3, resp_valid exactly 34 cycles after accept (1 cycle with MDU_FAST_MUL_EN).
- a=b=0xFFFFFFFF → MULHU=0xFFFFFFFE, MULH=0x00000000, MULHSU=0xFFFFFFFF, MUL=0x00000001.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with latency 1; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, latency 1.
- Hold resp_ready=0 for 10 cycles in DONE → resp_valid, resp_result and resp_tag stable, req_ready=0. One resp_ready pulse → req_ready=1 the next cycle.
- flush 10 cycles into CALC → no resp_valid, IDLE next cycle; a following DIVU 100/7 returns 14. Assert rst mid-CALC → all outputs at reset values and no stale response.
